gate16_sequencer: RTL and testbench

//  Multi-cycle controller that evaluates composite 16-bit logic ops (NAND, NOR, XOR, ...)
//  by sequencing ONE shared Not16/And16/Or16 gate stage, one micro-step per clock.

---
 rtl/gate16_sequencer.sv | 167 ++++++++++++++++
 tb/tb_gate16_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/gate16_sequencer.sv
// gate16_sequencer: evaluates composite 16-bit logic ops by sequencing one shared NOT/AND/OR stage.
// Optional completed-op counter (ops_done port) enabled by defining GATE16_SEQ_CNT_EN.
module gate16_sequencer #(
    parameter int unsigned WIDTH = 16
`ifdef GATE16_SEQ_CNT_EN
    , parameter int unsigned CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef GATE16_SEQ_CNT_EN
    , output logic [CNT_W-1:0] ops_done
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} seqStateT;
    typedef enum logic [2:0] {OP_NOT, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_ANDN, OP_XOR, OP_XNOR} opT;
    typedef enum logic [1:0] {GATE_NOT, GATE_AND, GATE_OR} gateT;
    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_T, SRC_U} srcT;

    seqStateT         state, nextState;
    opT               opReg;
    logic [WIDTH-1:0] aReg, bReg, tReg, uReg, outData;
    logic [2:0]       step;

    gateT             gate;
    srcT              srcX, srcY;
    logic             writeU, lastStep;
    logic [WIDTH-1:0] xVal, yVal, gateOut;

    // Micro-step decode: which gate, which operands, which temp, and whether this step finishes the op.
    always_comb begin
        gate     = GATE_AND;
        srcX     = SRC_A;
        srcY     = SRC_B;
        writeU   = 1'b0;
        lastStep = 1'b0;
        unique case (opReg)
            OP_NOT: begin gate = GATE_NOT; lastStep = 1'b1; end
            OP_AND: lastStep = 1'b1;
            OP_OR:  begin gate = GATE_OR; lastStep = 1'b1; end
            OP_NAND, OP_NOR: begin
                if (step == 3'd0) begin
                    gate = (opReg == OP_NAND) ? GATE_AND : GATE_OR;
                end else begin
                    gate     = GATE_NOT;
                    srcX     = SRC_T;
                    lastStep = 1'b1;
                end
            end
            OP_ANDN: begin
                if (step == 3'd0) begin
                    gate = GATE_NOT;
                    srcX = SRC_B;
                end else begin
                    srcY     = SRC_T;
                    lastStep = 1'b1;
                end
            end
            default: begin
                unique case (step)
                    3'd0: ;
                    3'd1: begin gate = GATE_NOT; srcX = SRC_T; end
                    3'd2: begin gate = GATE_OR; writeU = 1'b1; end
                    3'd3: begin
                        srcX     = SRC_T;
                        srcY     = SRC_U;
                        lastStep = (opReg == OP_XOR);
                    end
                    default: begin gate = GATE_NOT; srcX = SRC_T; lastStep = 1'b1; end
                endcase
            end
        endcase
    end

    always_comb begin
        unique case (srcX)
            SRC_A:   xVal = aReg;
            SRC_B:   xVal = bReg;
            SRC_T:   xVal = tReg;
            default: xVal = uReg;
        endcase
        unique case (srcY)
            SRC_A:   yVal = aReg;
            SRC_B:   yVal = bReg;
            SRC_T:   yVal = tReg;
            default: yVal = uReg;
        endcase
    end

    always_comb begin
        gateOut = '0;
        unique case (gate)
            GATE_NOT: gateOut = ~xVal;
            GATE_AND: gateOut = xVal & yVal;
            GATE_OR:  gateOut = xVal | yVal;
            default:  gateOut = '0;
        endcase
    end

    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = EXEC;
            end
            EXEC: if (lastStep) nextState = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // out_data has its own register so it holds across the next op's EXEC steps.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            opReg   <= OP_NOT;
            aReg    <= '0;
            bReg    <= '0;
            tReg    <= '0;
            uReg    <= '0;
            step    <= '0;
            outData <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && in_valid) begin
                opReg <= opT'(in_op);
                aReg  <= in_a;
                bReg  <= in_b;
                step  <= '0;
            end else if (state == EXEC) begin
                if (writeU) uReg <= gateOut;
                else        tReg <= gateOut;
                step <= step + 3'd1;
                if (lastStep) outData <= gateOut;
            end
        end
    end

    assign out_data = outData;

`ifdef GATE16_SEQ_CNT_EN
    logic [CNT_W-1:0] opsCnt;

    always_ff @(posedge clk) begin
        if (reset)                       opsCnt <= '0;
        else if (out_valid && out_ready) opsCnt <= opsCnt + CNT_W'(1);
    end

    assign ops_done = opsCnt;
`endif

endmodule

// File: tb/tb_gate16_sequencer.sv
// Directed self-checking bench for gate16_sequencer; counter checks compile in with GATE16_SEQ_CNT_EN.
module tb_gate16_sequencer;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  in_op;
    logic [15:0] in_a, in_b, out_data;
`ifdef GATE16_SEQ_CNT_EN
    logic [1:0]  ops_done;
`endif

    int passCnt = 0;
    int totalCnt = 0;

    gate16_sequencer #(
        .WIDTH(16)
`ifdef GATE16_SEQ_CNT_EN
        , .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef GATE16_SEQ_CNT_EN
        , .ops_done(ops_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_op = '0; in_a = '0; in_b = '0;
        tick(); tick();
        reset = 1'b0;
        totalCnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passCnt++;
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passCnt++;
        totalCnt++; if (out_data !== 16'h0000) $display("FAIL reset_out_data got %h want 0000", out_data); else passCnt++;
`ifdef GATE16_SEQ_CNT_EN
        totalCnt++; if (ops_done !== 2'd0) $display("FAIL reset_ops_done got %0d want 0", ops_done); else passCnt++;
`endif
    endtask

    task automatic test_and();
        int lat;
        out_ready = 1'b1;
        issue(3'd1, 16'h00FF, 16'h0F0F);
        waitValid(lat);
        totalCnt++; if (lat !== 1) $display("FAIL and_latency got %0d want 1", lat); else passCnt++;
        totalCnt++; if (out_data !== 16'h000F) $display("FAIL and_data got %h want 000F", out_data); else passCnt++;
        tick();
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL and_handoff_valid got %b want 0", out_valid); else passCnt++;
        totalCnt++; if (in_ready !== 1'b1) $display("FAIL and_handoff_ready got %b want 1", in_ready); else passCnt++;
    endtask

    task automatic test_xor();
        int lat;
        logic readyLeak;
        out_ready = 1'b1;
        issue(3'd6, 16'h5555, 16'hFFFF);
        in_a = 16'h0000; in_b = 16'h1234;
        readyLeak = (in_ready !== 1'b0);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
            if (in_ready !== 1'b0) readyLeak = 1'b1;
        end
        totalCnt++; if (lat !== 4) $display("FAIL xor_latency got %0d want 4", lat); else passCnt++;
        totalCnt++; if (out_data !== 16'hAAAA) $display("FAIL xor_data got %h want AAAA", out_data); else passCnt++;
        totalCnt++; if (readyLeak !== 1'b0) $display("FAIL xor_in_ready_busy got %b want 0", readyLeak); else passCnt++;
        tick();
    endtask

    task automatic test_xnor_nand();
        int lat;
        out_ready = 1'b1;
        issue(3'd7, 16'hF0F0, 16'hF00F);
        waitValid(lat);
        totalCnt++; if (lat !== 5) $display("FAIL xnor_latency got %0d want 5", lat); else passCnt++;
        totalCnt++; if (out_data !== 16'hFF00) $display("FAIL xnor_data got %h want FF00", out_data); else passCnt++;
        tick();
        issue(3'd3, 16'hFFFF, 16'hFFFF);
        waitValid(lat);
        totalCnt++; if (lat !== 2) $display("FAIL nand_latency got %0d want 2", lat); else passCnt++;
        totalCnt++; if (out_data !== 16'h0000) $display("FAIL nand_data got %h want 0000", out_data); else passCnt++;
        tick();
    endtask

    task automatic test_other_ops();
        logic [2:0]  ops  [5] = '{3'd0, 3'd2, 3'd4, 3'd5, 3'd6};
        logic [15:0] as   [5] = '{16'h1234, 16'h00F0, 16'h00F0, 16'hFF00, 16'h1234};
        logic [15:0] bs   [5] = '{16'h0000, 16'h0F00, 16'h0F00, 16'h0F0F, 16'hFFFF};
        logic [15:0] exps [5] = '{16'hEDCB, 16'h0FF0, 16'hF00F, 16'hF000, 16'hEDCB};
        int          lats [5] = '{1, 1, 2, 2, 4};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            waitValid(lat);
            totalCnt++; if (lat !== lats[i]) $display("FAIL op%0d_latency got %0d want %0d", ops[i], lat, lats[i]); else passCnt++;
            totalCnt++; if (out_data !== exps[i]) $display("FAIL op%0d_data got %h want %h", ops[i], out_data, exps[i]); else passCnt++;
            tick();
        end
    endtask

    task automatic test_hold();
        int lat;
        out_ready = 1'b0;
        issue(3'd1, 16'hFFFF, 16'h1234);
        waitValid(lat);
        in_valid = 1'b1; in_op = 3'd0; in_a = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            totalCnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid cycle %0d got %b want 1", i, out_valid); else passCnt++;
            totalCnt++; if (out_data !== 16'h1234) $display("FAIL hold_data cycle %0d got %h want 1234", i, out_data); else passCnt++;
            totalCnt++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready cycle %0d got %b want 0", i, in_ready); else passCnt++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL hold_release got %b want 0", out_valid); else passCnt++;
        issue(3'd6, 16'h0F0F, 16'h00FF);
        totalCnt++; if (out_data !== 16'h1234) $display("FAIL hold_data_after_handoff got %h want 1234", out_data); else passCnt++;
        waitValid(lat);
        totalCnt++; if (out_data !== 16'h0FF0) $display("FAIL hold_next_data got %h want 0FF0", out_data); else passCnt++;
        tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        out_ready = 1'b1;
        issue(3'd6, 16'h5555, 16'hFFFF);
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL abort_valid got %b want 0", out_valid); else passCnt++;
        totalCnt++; if (in_ready !== 1'b1) $display("FAIL abort_in_ready got %b want 1", in_ready); else passCnt++;
        totalCnt++; if (out_data !== 16'h0000) $display("FAIL abort_data got %h want 0000", out_data); else passCnt++;
        tick(); tick();
        totalCnt++; if (out_valid !== 1'b0) $display("FAIL abort_no_result got %b want 0", out_valid); else passCnt++;
        issue(3'd0, 16'h0000, 16'h0000);
        waitValid(lat);
        totalCnt++; if (lat !== 1) $display("FAIL abort_not_latency got %0d want 1", lat); else passCnt++;
        totalCnt++; if (out_data !== 16'hFFFF) $display("FAIL abort_not_data got %h want FFFF", out_data); else passCnt++;
        tick();
    endtask

    task automatic test_back_to_back();
        int firstV = -1, lastV = -1, nV = 0;
        logic [15:0] firstData = '0;
        out_ready = 1'b1;
        in_valid = 1'b1; in_op = 3'd3; in_a = 16'hF0F0; in_b = 16'hFF00;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (out_valid === 1'b1) begin
                if (firstV < 0) begin firstV = i; firstData = out_data; end
                lastV = i;
                nV++;
            end
        end
        in_valid = 1'b0;
        tick(); tick(); tick();
        totalCnt++; if (nV !== 3) $display("FAIL b2b_count got %0d want 3", nV); else passCnt++;
        totalCnt++; if (firstV !== 3) $display("FAIL b2b_first got %0d want 3", firstV); else passCnt++;
        totalCnt++; if (lastV !== 11) $display("FAIL b2b_last got %0d want 11", lastV); else passCnt++;
        totalCnt++; if (firstData !== 16'h0FFF) $display("FAIL b2b_data got %h want 0FFF", firstData); else passCnt++;
    endtask

`ifdef GATE16_SEQ_CNT_EN
    task automatic test_counter();
        logic [1:0] exp [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        int lat;
        reset = 1'b1; tick(); reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(3'd2, 16'h0001, 16'h0002);
            waitValid(lat);
            tick();
            totalCnt++; if (ops_done !== exp[i]) $display("FAIL cnt_op%0d got %0d want %0d", i, ops_done, exp[i]); else passCnt++;
        end
        issue(3'd7, 16'h0001, 16'h0002);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        issue(3'd0, 16'h0000, 16'h0000);
        waitValid(lat);
        tick();
        totalCnt++; if (ops_done !== 2'd1) $display("FAIL cnt_after_abort got %0d want 1", ops_done); else passCnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_and();
        test_xor();
        test_xnor_nand();
        test_other_ops();
        test_hold();
        test_reset_abort();
        test_back_to_back();
`ifdef GATE16_SEQ_CNT_EN
        test_counter();
`endif
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
